instruction_prefetch_unit: RTL and testbench
============================================

Name: instruction_prefetch_unit

Overview:
- Fetch stage between the program-memory ROM (5-bit address, 59-bit instruction, combinational read) and the top-level instruction decode controller.
- Autonomously drives the ROM address and buffers fetched instructions in a small FIFO.
- Presents the queue head to the decode controller through a valid/ack handshake.
- Accepts a PC redirect from the controller (jump/branch): flushes the queue and restarts fetching at the new PC.

Parameters:
- ADDR_W, 5, program address width; PC space is 2**ADDR_W words.
- INSTR_W, 59, instruction word width.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- CNT_W, 3, width of the occupancy count; must hold 0..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_enable  in  1  1 = fetching permitted; 0 = hold fetch PC, no queue writes.
- mem_addr  out  ADDR_W  address to program ROM; equals the internal fetch PC.
- mem_data  in  INSTR_W  ROM read data for mem_addr, valid in the same cycle.
- instr_valid  out  1  queue head valid (count != 0).
- instr_out  out  INSTR_W  instruction at queue head.
- instr_pc  out  ADDR_W  PC of the queue-head instruction.
- instr_ack  in  1  consumer takes the head this cycle; ignored when instr_valid=0.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch PC.
- queue_count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=0, async): state=BOOT, fetch_pc=0, mem_addr=0, rd/wr pointers=0, queue_count=0, instr_valid=0, instr_out=0, instr_pc=0. Queue storage need not be cleared.
- State machine: BOOT, FETCH, FULL, HALT.
  - BOOT: one cycle after reset release, no write, then go to FETCH. Covers the ROM settling on address 0.
  - FETCH: at each edge, if fetch_enable=1 and the queue accepts a write, write {mem_data, fetch_pc} at wr_ptr and set fetch_pc <= fetch_pc+1.
    - Go to FULL when the post-edge count = DEPTH.
    - Go to HALT when fetch_enable=0.
  - FULL: no write unless instr_ack=1 in the same cycle. In that case write and pop together; count stays DEPTH and the state stays FULL. Go to FETCH when a pop occurs without a write.
  - HALT: no writes. Pops continue. Return to FETCH when fetch_enable=1.
- The queue accepts a write when count < DEPTH, or count = DEPTH with instr_ack=1.
- Pop: instr_ack=1 and count!=0 advances rd_ptr.
- Simultaneous pop and write leaves count unchanged.
- Writing into an empty queue makes instr_valid=1 on the next cycle. Fetch-to-valid latency is 1 cycle.
- Head outputs (instr_valid, instr_out, instr_pc) are registered, with no combinational path from mem_data.
- Redirect has highest priority, above pop, write and fetch_enable.
  - On the edge with redirect_valid=1: pointers=0, count=0, fetch_pc<=redirect_pc. The current mem_data is discarded and the ack is consumed but irrelevant.
  - State goes to FETCH, or to HALT if fetch_enable=0.
  - On the next cycle instr_valid=0 and mem_addr=redirect_pc.
  - The first post-redirect instruction is valid 2 cycles after the redirect edge.
- PC arithmetic is modulo 2**ADDR_W: 31+1 wraps to 0 with no flag and no stall.
- Pointers wrap modulo DEPTH.
- queue_count never exceeds DEPTH and never underflows. An ack on an empty queue is a no-op.
- fetch_enable deasserted during BOOT: go to HALT after BOOT.
- Reset asserted mid-operation: immediate return to reset values regardless of state. In-flight data is lost.

Test Plan:
- ROM word k = {54'h0, k[4:0]}. Release reset with fetch_enable=1 and instr_ack=0: after the BOOT cycle, queue_count goes 1,2,3,4 on consecutive cycles. instr_pc=0, instr_out=0x0, mem_addr holds 4, state FULL.
- Continuous instr_ack=1 from the first instr_valid: instr_pc goes 0,1,2,... one per cycle, queue_count stays 1, and there are no gaps.
- Queue full (PCs 0..3), then pulse redirect_valid with redirect_pc=17 and instr_ack=1: the next cycle has queue_count=0, instr_valid=0 and mem_addr=17. The one after has instr_valid=1 and instr_pc=17.
- Redirect to 30 with continuous ack: instr_pc sequence is 30,31,0,1, covering the wrap.
- Drop fetch_enable with queue_count=2 and ack held: both entries drain, then instr_valid=0 and mem_addr frozen. Re-enabling resumes from the frozen PC with no skipped address.
- Assert rst asynchronously between edges while the queue is full: outputs go to 0 immediately. After release, fetch restarts at PC 0 after one BOOT cycle.

Source files
------------

// File: rtl/instruction_prefetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_prefetch_unit
//
// Fetch stage between the program ROM and the decode controller. Walks the
// ROM address autonomously, buffers {instruction, pc} pairs in a small FIFO
// and presents the queue head through a valid/ack handshake. A redirect
// flushes the queue and restarts fetching at the new PC.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   fetch_enable   1 = fetching permitted; 0 = hold fetch PC, no queue writes
//   mem_addr       ROM address (the internal fetch PC)
//   mem_data       ROM read data for mem_addr, valid in the same cycle
//   instr_valid    queue head valid (occupancy != 0)
//   instr_out      instruction at the queue head (registered)
//   instr_pc       PC of the queue-head instruction (registered)
//   instr_ack      consumer takes the head this cycle
//   redirect_valid flush the queue and restart fetch at redirect_pc
//   redirect_pc    new fetch PC
//   queue_count    current occupancy
// ----------------------------------------------------------------------------
module instruction_prefetch_unit #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 59,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_enable,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ack,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0]   queue_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_inc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               pop;
    logic               wr_en;
    logic               head_from_fetch;
    logic               head_from_mem;

    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    always_comb begin
        pop             = 1'b0;
        wr_en           = 1'b0;
        count_next      = count;
        state_next      = state;
        head_from_fetch = 1'b0;
        head_from_mem   = 1'b0;
        rd_ptr_inc      = rd_ptr + PTR_W'(1);

        if (redirect_valid) begin
            // Redirect overrides pop, write and fetch_enable.
            count_next = '0;
            state_next = fetch_enable ? ST_FETCH : ST_HALT;
        end else begin
            pop   = instr_ack && (count != '0);
            // A full queue still accepts a write when the head leaves this cycle.
            wr_en = fetch_enable
                    && ((state == ST_FETCH) || (state == ST_FULL))
                    && ((count != FULL_CNT) || instr_ack);
            count_next = count + CNT_W'(wr_en) - CNT_W'(pop);

            // The new word becomes the head when nothing older remains after the pop.
            head_from_fetch = wr_en && ((count == '0) || (pop && (count == CNT_W'(1))));
            // Otherwise a pop exposes the next stored entry.
            head_from_mem   = pop && (count > CNT_W'(1));

            case (state)
                ST_BOOT, ST_HALT: state_next = fetch_enable ? ST_FETCH : ST_HALT;
                default: begin
                    if (!fetch_enable)
                        state_next = ST_HALT;
                    else if (count_next == FULL_CNT)
                        state_next = ST_FULL;
                    else
                        state_next = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_BOOT;
            fetch_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr_inc;
            end
        end
    end

    // Queue storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr] <= mem_data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    // Head registers are loaded from the post-edge queue head, either bypassing
    // the word being fetched or reading the next stored entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out <= '0;
            instr_pc  <= '0;
        end else if (head_from_fetch) begin
            instr_out <= mem_data;
            instr_pc  <= fetch_pc;
        end else if (head_from_mem) begin
            instr_out <= data_mem[rd_ptr_inc];
            instr_pc  <= pc_mem[rd_ptr_inc];
        end
    end

    assign mem_addr    = fetch_pc;
    assign queue_count = count;
    assign instr_valid = (count != '0);

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_prefetch_unit
//
// Drives instruction_prefetch_unit against a hashed combinational ROM and
// compares every cycle against a queue-based model of the fetch stage, plus
// directed literal expectations for boot fill, redirect, PC wrap, fetch
// disable/re-enable and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_instruction_prefetch_unit;

    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 59;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_enable;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ack;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [CNT_W-1:0]   queue_count;

    int checks = 0;
    int errors = 0;

    // Model state
    int unsigned m_q[$];
    int unsigned m_pc   = 0;
    bit          m_boot = 1'b1;
    bit          m_halt = 1'b0;

    instruction_prefetch_unit #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_enable  (fetch_enable),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_ack     (instr_ack),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .queue_count   (queue_count)
    );

    always #5 clk = ~clk;

    // Word 0 is zero; other words are distinct so data/pc mix-ups show up.
    function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [53:0] h;
        h = 54'(a) * 54'h13C4B5A6978871;
        return {a, h};
    endfunction

    assign mem_data = rom_word(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of PCs, a fetch PC, a boot flag and a halt flag.
    initial begin
        bit can_wr;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_pc   = 0;
                m_boot = 1'b1;
                m_halt = 1'b0;
            end else begin
                if (m_boot) begin
                    m_boot = 1'b0;
                end else if (redirect_valid) begin
                    m_q.delete();
                    m_pc = int'(redirect_pc);
                end else begin
                    can_wr = !m_halt && fetch_enable
                             && ((m_q.size() < DEPTH) || instr_ack);
                    if (instr_ack && (m_q.size() != 0))
                        void'(m_q.pop_front());
                    if (can_wr) begin
                        m_q.push_back(m_pc);
                        m_pc = (m_pc + 1) % (1 << ADDR_W);
                    end
                end
                // Any cycle with fetch disabled leaves the unit halted; the
                // first enabled cycle afterwards only restarts, it writes nothing.
                m_halt = !fetch_enable;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("m_count", 64'(queue_count), 64'(m_q.size()));
                check("m_valid", 64'(instr_valid), 64'(m_q.size() != 0));
                check("m_addr",  64'(mem_addr),    64'(m_pc));
                if (m_q.size() != 0) begin
                    check("m_pc",  64'(instr_pc),  64'(m_q[0]));
                    check("m_out", 64'(instr_out), 64'(rom_word(ADDR_W'(m_q[0]))));
                end
            end
        end
    end

    initial begin
        int unsigned exp_wrap[4];
        exp_wrap = '{30, 31, 0, 1};

        rst            = 1'b0;
        fetch_enable   = 1'b1;
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Boot and fill
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("boot_count", 64'(queue_count), 64'd0);
        check("boot_addr",  64'(mem_addr),    64'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            check("fill_count", 64'(queue_count), 64'(k));
        end
        check("fill_pc",   64'(instr_pc),  64'd0);
        check("fill_out",  64'(instr_out), 64'd0);
        check("fill_addr", 64'(mem_addr),  64'd4);

        // Redirect from a full queue
        redirect_valid = 1'b1;
        redirect_pc    = 5'd17;
        instr_ack      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ack      = 1'b0;
        check("redir_count", 64'(queue_count), 64'd0);
        check("redir_valid", 64'(instr_valid), 64'd0);
        check("redir_addr",  64'(mem_addr),    64'd17);
        @(negedge clk);
        check("redir_valid2", 64'(instr_valid), 64'd1);
        check("redir_pc",     64'(instr_pc),    64'd17);

        // Redirect near the top of PC space with continuous ack
        redirect_valid = 1'b1;
        redirect_pc    = 5'd30;
        instr_ack      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_pc",    64'(instr_pc),    64'(exp_wrap[i]));
            check("wrap_count", 64'(queue_count), 64'd1);
        end

        // Fetch disable with two entries queued, then re-enable
        instr_ack = 1'b0;
        @(negedge clk);
        check("halt_count2", 64'(queue_count), 64'd2);
        fetch_enable = 1'b0;
        instr_ack    = 1'b1;
        @(negedge clk);
        check("halt_count1", 64'(queue_count), 64'd1);
        check("halt_pc",     64'(instr_pc),    64'd2);
        @(negedge clk);
        check("halt_valid", 64'(instr_valid), 64'd0);
        check("halt_addr",  64'(mem_addr),    64'd3);
        @(negedge clk);
        check("halt_frozen", 64'(mem_addr), 64'd3);
        fetch_enable = 1'b1;
        @(negedge clk);
        check("resume_count", 64'(queue_count), 64'd0);
        @(negedge clk);
        check("resume_valid", 64'(instr_valid), 64'd1);
        check("resume_pc",    64'(instr_pc),    64'd3);

        // Randomized traffic; ack probability rises per segment
        for (int seg = 0; seg < 5; seg++) begin
            for (int c = 0; c < 300; c++) begin
                fetch_enable   = ($urandom_range(0, 9) != 0);
                instr_ack      = ($urandom_range(0, 3) < seg);
                redirect_valid = ($urandom_range(0, 29) == 0);
                redirect_pc    = ADDR_W'($urandom_range(0, 31));
                @(negedge clk);
            end
        end

        // Fill, then asynchronous reset between edges
        fetch_enable   = 1'b1;
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_count", 64'(queue_count), 64'd4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", 64'(queue_count), 64'd0);
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_addr",  64'(mem_addr),    64'd0);
        check("arst_pc",    64'(instr_pc),    64'd0);
        check("arst_out",   64'(instr_out),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reboot_count", 64'(queue_count), 64'd0);
        check("reboot_addr",  64'(mem_addr),    64'd0);
        @(negedge clk);
        check("reboot_count1", 64'(queue_count), 64'd1);
        check("reboot_pc",     64'(instr_pc),    64'd0);
        check("reboot_addr1",  64'(mem_addr),    64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
